// File: rtl/coffee_pkg.sv
// Shared coffee-machine types: payment FSM states and currency width.
package coffee_pkg;

    localparam int unsigned CURRENCY_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        VEND,
        REFUND
    } state_t;

endpackage

// File: rtl/coin_payment_fsm_adder.sv
// Shared adder/flag unit: s = a + b + cin with carry, zero, negative and signed-overflow flags.
module coin_payment_fsm_adder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  cout,
    output logic                  z,
    output logic                  n,
    output logic                  o
);

    logic [DATA_WIDTH:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b} + (DATA_WIDTH+1)'(cin);
    assign s    = sum[DATA_WIDTH-1:0];
    assign cout = sum[DATA_WIDTH];
    assign z    = (s == '0);
    assign n    = s[DATA_WIDTH-1];
    assign o    = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

endmodule

// File: rtl/coin_payment_fsm.sv
// Coin payment controller: accumulates credit, compares it to the price through the
// shared adder, requests a vend and reports change or refund.
module coin_payment_fsm
    import coffee_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CURRENCY_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] price,
    input  logic                  coin_valid,
    input  logic [DATA_WIDTH-1:0] coin_value,
    input  logic                  cancel,
    input  logic                  vend_ack,
    output logic [DATA_WIDTH-1:0] credit,
    output logic                  vend_req,
    output logic [DATA_WIDTH-1:0] change,
    output logic                  change_valid,
    output logic                  exact_pay,
    output logic                  coin_reject,
    output logic                  busy
);

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] price_q, price_d;
    logic [DATA_WIDTH-1:0] credit_d, change_d;
    logic                  vend_req_d, change_valid_d, exact_pay_d, coin_reject_d, busy_d;

    logic [DATA_WIDTH-1:0] add_b, add_s;
    logic                  add_cin, add_cout, add_z;
    logic                  unused_n, unused_o;

    // CHECK computes credit - price as credit + ~price + 1; otherwise credit + coin
    always_comb begin
        add_b   = coin_value;
        add_cin = 1'b0;
        if (state == CHECK) begin
            add_b   = ~price_q;
            add_cin = 1'b1;
        end
    end

    coin_payment_fsm_adder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_adder (
        .a   (credit),
        .b   (add_b),
        .cin (add_cin),
        .s   (add_s),
        .cout(add_cout),
        .z   (add_z),
        .n   (unused_n),
        .o   (unused_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            price_q      <= '0;
            credit       <= '0;
            change       <= '0;
            vend_req     <= 1'b0;
            change_valid <= 1'b0;
            exact_pay    <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            price_q      <= price_d;
            credit       <= credit_d;
            change       <= change_d;
            vend_req     <= vend_req_d;
            change_valid <= change_valid_d;
            exact_pay    <= exact_pay_d;
            coin_reject  <= coin_reject_d;
            busy         <= busy_d;
        end
    end

    // A coin is rejected unless it is accepted into credit in COLLECT
    always_comb begin
        state_d        = state;
        price_d        = price_q;
        credit_d       = credit;
        change_d       = change;
        exact_pay_d    = exact_pay;
        change_valid_d = 1'b0;
        coin_reject_d  = coin_valid;

        case (state)
            IDLE: begin
                if (start) begin
                    price_d = price;
                    state_d = CHECK;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_d = REFUND;
                end else if (coin_valid && !add_cout) begin
                    credit_d      = add_s;
                    coin_reject_d = 1'b0;
                    state_d       = CHECK;
                end
            end
            CHECK: begin
                if (cancel) begin
                    state_d = REFUND;
                end else if (add_cout) begin
                    change_d    = add_s;
                    exact_pay_d = add_z;
                    state_d     = VEND;
                end else begin
                    state_d = COLLECT;
                end
            end
            VEND: begin
                if (vend_ack) begin
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    state_d        = IDLE;
                end
            end
            REFUND: begin
                change_d       = credit;
                change_valid_d = 1'b1;
                credit_d       = '0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == IDLE) && (state != IDLE)) begin
            exact_pay_d = 1'b0;
        end
        vend_req_d = (state_d == VEND);
        busy_d     = (state_d != IDLE);
    end

endmodule
